// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART TX arbiter.
// Imported by the picker and the arbiter top.
package uart_arb_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_IDLE_TIMEOUT = 1024;
  localparam int DEF_MAX_PKT      = 256;
  localparam int ID_W             = $clog2(DEF_NUM_REQ);

  // Requester-id width, kept at least 1 bit wide.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream handshake bundle between the requesters and the UART TX.
// The slave modport is the arbiter side; the master modport is the requester/UART side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           tx_valid;
  logic [DATA_W-1:0]              tx_data;
  logic                           tx_ready;

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data
  );
  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request after last_grant,
// wrapping around.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IW      = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic               any_req,
  output logic [IW-1:0]      pick_id
);
  int idx;

  // Scan from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    any_req = |req;
    pick_id = last_grant;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (req[idx]) pick_id = IW'(idx);
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of a single UART TX byte port.
// Stalled or over-long grants are revoked so no requester can hog the link.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ      = DEF_NUM_REQ,
  parameter  int DATA_W       = DEF_DATA_W,
  parameter  int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter  int MAX_PKT      = DEF_MAX_PKT,
  localparam int IW           = id_w(NUM_REQ)
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus,
  output logic              grant_active,
  output logic [IW-1:0]     grant_id,
  output logic              timeout_err,
  output logic              overrun_err,
  output logic [IW-1:0]     err_src
);
  localparam int BC_W = $clog2(MAX_PKT + 1);
  localparam int SC_W = $clog2(IDLE_TIMEOUT + 1);

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   last_grant, last_grant_nxt, grant_id_nxt, err_src_nxt, pick_id;
  logic [BC_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [SC_W-1:0] stall_cnt, stall_cnt_nxt;
  logic            timeout_nxt, overrun_nxt, any_req, g_valid, g_last, xfer;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .any_req    (any_req),
    .pick_id    (pick_id)
  );

  assign g_valid      = bus.req_valid[grant_id];
  assign g_last       = bus.req_last[grant_id];
  assign xfer         = (state == GRANT) && g_valid && bus.tx_ready;
  assign grant_active = (state == GRANT);

  // Pass-through datapath: only the owner sees tx_ready.
  always_comb begin
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus.req_ready = '0;
    if (state == GRANT) begin
      bus.tx_valid            = g_valid;
      bus.tx_data             = bus.req_data[grant_id];
      bus.req_ready[grant_id] = bus.tx_ready;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_id_nxt   = grant_id;
    err_src_nxt    = err_src;
    byte_cnt_nxt   = byte_cnt;
    stall_cnt_nxt  = stall_cnt;
    timeout_nxt    = 1'b0;
    overrun_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_id_nxt  = pick_id;
          byte_cnt_nxt  = '0;
          stall_cnt_nxt = '0;
          state_nxt     = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          byte_cnt_nxt  = byte_cnt + BC_W'(1);
          stall_cnt_nxt = '0;
          // A real last on the MAX_PKT-th byte ends the packet cleanly.
          if (g_last || byte_cnt == BC_W'(MAX_PKT - 1)) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant_id;
            if (!g_last) begin
              overrun_nxt = 1'b1;
              err_src_nxt = grant_id;
            end
          end
        end else if (!g_valid) begin
          if (stall_cnt == SC_W'(IDLE_TIMEOUT - 1)) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant_id;
            timeout_nxt    = 1'b1;
            err_src_nxt    = grant_id;
          end else begin
            stall_cnt_nxt = stall_cnt + SC_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= IW'(NUM_REQ - 1);
      grant_id    <= '0;
      err_src     <= '0;
      byte_cnt    <= '0;
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      grant_id    <= grant_id_nxt;
      err_src     <= err_src_nxt;
      byte_cnt    <= byte_cnt_nxt;
      stall_cnt   <= stall_cnt_nxt;
      timeout_err <= timeout_nxt;
      overrun_err <= overrun_nxt;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single packet, round-robin, backpressure,
// idle timeout, overrun, last/MAX_PKT coincidence and async reset mid-packet.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int MP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       grant_active, timeout_err, overrun_err;
  logic [1:0] grant_id, err_src;
  int         checks = 0;
  int         errors = 0;
  int         idx;
  int         ord [4] = '{0, 1, 2, 0};

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .IDLE_TIMEOUT(TO), .MAX_PKT(MP)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .grant_active (grant_active),
    .grant_id     (grant_id),
    .timeout_err  (timeout_err),
    .overrun_err  (overrun_err),
    .err_src      (err_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int i, input logic v, input logic [7:0] d, input logic l);
    bus.req_valid[i] = v;
    bus.req_data[i]  = d;
    bus.req_last[i]  = l;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b0;

    // reset state
    tick; tick;
    chk("rst_grant_active", grant_active, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_overrun", overrun_err, 0);
    chk("rst_err_src", err_src, 0);
    reset = 1'b1;

    // single requester, 3-byte packet
    bus.tx_ready = 1'b1;
    drive(0, 1, 8'h41, 0); #1;
    chk("t1_no_grant_yet", grant_active, 0);
    tick;
    chk("t1_grant_active", grant_active, 1);
    chk("t1_grant_id", grant_id, 0);
    chk("t1_tx_valid", bus.tx_valid, 1);
    chk("t1_byte0", bus.tx_data, 8'h41);
    chk("t1_req_ready", bus.req_ready, 4'b0001);
    tick; drive(0, 1, 8'h42, 0); #1;
    chk("t1_byte1", bus.tx_data, 8'h42);
    tick; drive(0, 1, 8'h43, 1); #1;
    chk("t1_byte2", bus.tx_data, 8'h43);
    tick; drive(0, 0, 8'h00, 0); #1;
    chk("t1_released", grant_active, 0);
    chk("t1_tx_valid_off", bus.tx_valid, 0);
    chk("t1_grant_id_hold", grant_id, 0);

    // round-robin from reset: 0,1,2 then 0 again
    reset = 1'b0; tick; reset = 1'b1;
    drive(0, 1, 8'h01, 0);
    drive(1, 1, 8'h11, 0);
    drive(2, 1, 8'h21, 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("rr_grant_active", grant_active, 1);
      chk("rr_grant_id", grant_id, ord[k]);
      chk("rr_byte0", bus.tx_data, 8'(ord[k] * 16 + 1));
      chk("rr_req_ready", bus.req_ready, 4'(1 << ord[k]));
      tick; drive(ord[k], 1, 8'(ord[k] * 16 + 2), 1); #1;
      chk("rr_byte1", bus.tx_data, 8'(ord[k] * 16 + 2));
      tick;
      if (k == 0) drive(0, 1, 8'h01, 0);
      else        drive(ord[k], 0, 8'h00, 0);
      #1;
      chk("rr_gap_idle", grant_active, 0);
    end

    // backpressure longer than the idle timeout on requester 1
    drive(1, 1, 8'hA1, 0);
    tick;
    idx = 0;
    for (int c = 0; c < 24; c++) begin
      bus.tx_ready = (c == 0 || c >= 21);
      drive(1, 1, 8'(8'hA1 + idx), idx == 3); #1;
      chk("bp_grant_active", grant_active, 1);
      chk("bp_tx_data", bus.tx_data, 8'(8'hA1 + idx));
      chk("bp_req_ready", bus.req_ready, {2'b00, bus.tx_ready, 1'b0});
      tick;
      chk("bp_no_timeout", timeout_err, 0);
      if (bus.tx_ready) idx++;
    end
    drive(1, 0, 8'h00, 0); bus.tx_ready = 1'b1; #1;
    chk("bp_released", grant_active, 0);

    // idle timeout on requester 2, requester 3 waiting
    drive(2, 1, 8'h55, 0);
    drive(3, 1, 8'h30, 0);
    tick;
    chk("to_grant_id", grant_id, 2);
    tick; drive(2, 0, 8'h00, 0); #1;
    chk("to_tx_valid_low", bus.tx_valid, 0);
    for (int s = 0; s < TO - 1; s++) begin
      tick;
      chk("to_still_granted", grant_active, 1);
      chk("to_no_pulse_yet", timeout_err, 0);
    end
    tick;
    chk("to_revoked", grant_active, 0);
    chk("to_pulse", timeout_err, 1);
    chk("to_err_src", err_src, 2);
    tick;
    chk("to_pulse_once", timeout_err, 0);
    chk("to_next_grant", grant_active, 1);
    chk("to_next_id", grant_id, 3);
    chk("to_next_data", bus.tx_data, 8'h30);

    // overrun: requester 3 streams without last
    for (int n = 0; n < MP; n++) begin
      chk("ov_grant_active", grant_active, 1);
      chk("ov_tx_data", bus.tx_data, 8'(8'h30 + n));
      chk("ov_no_pulse_yet", overrun_err, 0);
      tick; drive(3, 1, 8'(8'h30 + n + 1), 0); #1;
    end
    chk("ov_released", grant_active, 0);
    chk("ov_pulse", overrun_err, 1);
    chk("ov_err_src", err_src, 3);
    chk("ov_tx_valid", bus.tx_valid, 0);
    drive(3, 0, 8'h00, 0);
    tick;
    chk("ov_pulse_once", overrun_err, 0);

    // last on byte MAX_PKT ends normally
    drive(0, 1, 8'h60, 0);
    tick;
    for (int n = 0; n < MP; n++) begin
      drive(0, 1, 8'(8'h60 + n), n == MP - 1); #1;
      chk("co_tx_data", bus.tx_data, 8'(8'h60 + n));
      tick;
    end
    drive(0, 0, 8'h00, 0); #1;
    chk("co_released", grant_active, 0);
    chk("co_no_overrun", overrun_err, 0);
    chk("co_err_src_hold", err_src, 3);

    // async reset mid-packet, then requester 0 has priority again
    drive(0, 1, 8'h77, 0);
    tick;
    chk("ar_grant_id", grant_id, 0);
    chk("ar_grant_active", grant_active, 1);
    tick;
    drive(0, 1, 8'h78, 0);
    drive(3, 1, 8'h99, 0);
    reset = 1'b0; #1;
    chk("ar_grant_dropped", grant_active, 0);
    chk("ar_tx_valid", bus.tx_valid, 0);
    chk("ar_tx_data", bus.tx_data, 0);
    chk("ar_req_ready", bus.req_ready, 0);
    chk("ar_err_src", err_src, 0);
    tick; reset = 1'b1;
    tick;
    chk("ar_regrant", grant_active, 1);
    chk("ar_prio0", grant_id, 0);
    chk("ar_data", bus.tx_data, 8'h78);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter in top_level between NUM_REQ byte-stream requesters (e.g. command responder, telemetry, debug echo).
- Grants whole packets in round-robin order and passes bytes to the UART TX byte interface with a valid/ready handshake.
- Releases a stalled or over-long grant so one requester cannot lock the serial link.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- IDLE_TIMEOUT, 1024, cycles the granted requester may hold req_valid low mid-packet before the grant is revoked.
- MAX_PKT, 256, maximum bytes per grant; byte MAX_PKT is treated as last.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  marks the final byte of a packet
- req_ready  out  NUM_REQ  per-requester byte accept
- tx_valid  out  1  byte valid to UART TX
- tx_data  out  DATA_W  byte to UART TX
- tx_ready  in  1  UART TX can accept a byte
- grant_active  out  1  a requester currently owns the link
- grant_id  out  $clog2(NUM_REQ)  current or most recent owner
- timeout_err  out  1  one-cycle pulse when a grant is revoked by IDLE_TIMEOUT
- overrun_err  out  1  one-cycle pulse when a grant is ended by MAX_PKT
- err_src  out  $clog2(NUM_REQ)  requester that caused the last error

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE; all outputs 0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - All counters cleared.
  - Reset mid-packet drops the grant immediately. No partial-byte recovery; the requester re-sends.
- FSM states are IDLE and GRANT.
- IDLE:
  - req_ready=0, tx_valid=0.
  - If any req_valid=1, pick the first set bit searching from last_grant+1 upward, with wrap-around.
  - Register grant_id, set grant_active=1, go to GRANT.
  - Arbitration latency is exactly 1 cycle from req_valid to grant_active.
- GRANT (g = grant_id), combinational pass-through:
  - tx_valid=req_valid[g]; tx_data=req_data[g]; req_ready[g]=tx_ready; all other req_ready=0.
  - A transfer occurs when req_valid[g] & tx_ready. On each transfer, byte_cnt increments and stall_cnt clears.
  - On a transfer with req_last[g]=1, or when byte_cnt reaches MAX_PKT-1 at transfer: last_grant=g, go to IDLE, grant_active=0 next cycle. In the MAX_PKT case, also pulse overrun_err and set err_src=g.
  - When req_valid[g]=0, stall_cnt increments. When it reaches IDLE_TIMEOUT-1: go to IDLE, last_grant=g, pulse timeout_err, set err_src=g.
  - When req_valid[g]=1 and tx_ready=0 (backpressure), stall_cnt holds and does not count.
- Between packets: at least one IDLE cycle. A requester holding req_valid across its last byte re-competes fairly and will not win again while others are waiting.
- Simultaneous events: if last and MAX_PKT coincide, end the packet normally with no overrun_err.
- Counter widths:
  - byte_cnt is $clog2(MAX_PKT+1) bits.
  - stall_cnt is $clog2(IDLE_TIMEOUT+1) bits.
  - Neither counter may wrap.
- grant_id holds its value in IDLE for debug visibility.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - default constants: DATA_W=8, IDLE_TIMEOUT, MAX_PKT;
  - the localparam ID_W=$clog2(NUM_REQ).
- Sub-module rr_picker: combinational round-robin selector.
  - Inputs: req vector, last_grant.
  - Outputs: any_req, pick_id.
  - Unit-testable on its own.

Test Plan:
- Single requester: req 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_ready=1 -> grant_active 1 cycle after req_valid; tx_data sequence 0x41,0x42,0x43; grant drops after 0x43.
- Round-robin: req 0,1,2 all valid with 2-byte packets from reset -> grant order 0,1,2, then 0 again if re-requested; never two consecutive grants to the same requester while others wait.
- Backpressure: tx_ready toggles 1,0,0,1 during req 1's 4-byte packet -> no byte lost or duplicated; stall_cnt does not advance; timeout_err stays 0.
- Timeout: req 2 sends 1 byte without last, then drops req_valid -> after IDLE_TIMEOUT cycles, timeout_err pulses once with err_src=2 and grant passes to the next waiting requester.
- Overrun: req 3 streams MAX_PKT+5 bytes without last -> exactly MAX_PKT bytes are forwarded, overrun_err pulses with err_src=3, and the grant is released.
- Async reset mid-packet: assert reset low between clock edges during GRANT -> all outputs 0 immediately; after release, requester 0 has priority.
